conv_window_feeder: RTL and testbench
=====================================

# conv_window_feeder

Downstream consumer of the image-load stage. Once a full image sits in the on-chip image buffer (16-bit words, row-major, N×N, up to 32×32 = 1024 words), this block walks the image with a 5×5 kernel window at stride 1. For every output position it fetches the 25 pixels through the buffer read port and presents them as one flattened window to the convolution datapath over a valid/ready handshake.

## Interface
Parameters:
- DATA_SIZE, 16, pixel word width
- ADDR_SIZE, 10, image-buffer address width (1024 words)
- MAX_IMG, 32, largest supported image side
- K, 5, kernel side; window holds K*K = 25 words

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a pass; sampled only in IDLE
- imgSize  in  6  image side N
- bufAddr  out  ADDR_SIZE  image-buffer read address
- bufData  in  DATA_SIZE  read data; valid exactly one cycle after bufAddr is presented
- window  out  K*K*DATA_SIZE  flattened window; tap t = i*K+j occupies bits [t*DATA_SIZE +: DATA_SIZE]
- windowValid  out  1  window holds a complete window for (outRow, outCol)
- windowReady  in  1  consumer accepts the window when windowValid && windowReady
- outRow, outCol  out  6 each  output coordinates of the current window
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of a pass

## Operation
- FSM states: IDLE, FETCH, EMIT, DONE.
- IDLE:
  - start=1 latches N = min(imgSize, 32) (values above 32 clamp to 32) and sets outDim = N-K+1.
  - If N < K, go to DONE. No window is produced.
  - Otherwise clear r and c to 0 and go to FETCH.
  - start is ignored in every other state.
- FETCH:
  - Issue 25 reads, one per cycle, in tap order t = 0..24 (i = t/5, j = t%5), at bufAddr = (r+i)*N + (c+j).
  - Compute the address at 11 bits and truncate to 10. The legal maximum is 31*32+31 = 1023.
  - Capture the data returned for tap t into window slot t one cycle after that tap's address was issued.
  - After slot 24 is written, go to EMIT.
- EMIT:
  - Hold windowValid=1.
  - window, outRow and outCol stay stable until the handshake.
  - On the handshake, advance position:
    - If c < outDim-1, increment c and go to FETCH.
    - Otherwise, if r < outDim-1, set c=0, increment r, and go to FETCH.
    - Otherwise go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Every window is refetched in full; there is no column reuse. One pass produces outDim² windows in raster order.

## Timing
- Reset values: bufAddr=0, window=all 0, windowValid=0, outRow=0, outCol=0, busy=0, done=0; state is IDLE.
- The rst=1 edge takes priority over everything, including mid-FETCH and mid-EMIT. A pending window is discarded and the pass is abandoned.
- Cycle numbering, with start sampled at edge 0:
  - Tap addresses drive bufAddr during cycles 1..25.
  - Data is captured at edges 2..26.
  - windowValid is high from edge 26 onward.
- Handshake to next window: if the handshake occurs at edge h, windowValid falls at h and rises again at h+26.
- Last handshake at edge h: done is high during cycle h..h+1. busy falls at h+1.
- N < K: done is high the cycle after start, and busy is high for that one cycle only.
- windowReady is ignored while windowValid=0.
- A handshake and rst at the same edge: rst wins and no advance occurs.

## Test plan
- N=5, buffer word a = a: exactly one window, with window slot t = t+5*(t/5)... no: slot t = (t/5)*5 + t%5, which is t. windowValid rises at edge 26, (outRow,outCol)=(0,0), and done pulses one cycle after the handshake.
- N=6, buffer word a = a, windowReady tied high: 4 windows at positions (0,0),(0,1),(1,0),(1,1). Tap 0 values are 0, 1, 6, 7. Tap 24 values are 28, 29, 34, 35. The gap between windows is 26 cycles.
- Backpressure with N=6: hold windowReady low for 10 cycles after windowValid. window, outRow and outCol must stay unchanged, and bufAddr must issue no new reads.
- N=3: done asserts at edge 1 and windowValid never asserts. start=1 pulsed while busy in an N=6 pass produces no effect.
- imgSize=40: clamped to 32, giving 784 windows. The final window is at (27,27) and its last tap address is 1023.
- rst asserted at cycle 12 of FETCH: every output returns to its reset value on the next edge. A fresh start then yields a correct first window at the normal latency.

Source files
------------

// File: rtl/conv_window_feeder_if.sv
// Window-feeder bus bundle: image-buffer read port plus the window valid/ready stream.
// master = feeder side, slave = buffer/consumer side.
interface conv_window_feeder_if #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned K         = 5
) ();

  logic [ADDR_SIZE-1:0]     bufAddr;
  logic [DATA_SIZE-1:0]     bufData;
  logic [K*K*DATA_SIZE-1:0] window;
  logic                     windowValid;
  logic                     windowReady;
  logic [5:0]               outRow;
  logic [5:0]               outCol;

  modport master (
    output bufAddr,
    input  bufData,
    output window,
    output windowValid,
    input  windowReady,
    output outRow,
    output outCol
  );

  modport slave (
    input  bufAddr,
    output bufData,
    input  window,
    input  windowValid,
    output windowReady,
    input  outRow,
    input  outCol
  );

endinterface

// File: rtl/conv_window_feeder.sv
// Walks an N x N image in the buffer with a KxK stride-1 window, fetching every tap per
// position and presenting the flattened window over a valid/ready handshake.
module conv_window_feeder #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned MAX_IMG   = 32,
  parameter int unsigned K         = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [5:0]                  imgSize,
  output logic                        busy,
  output logic                        done,
  conv_window_feeder_if.master        bus
);

  localparam int unsigned Taps      = K * K;
  localparam int unsigned CntW      = $clog2(Taps + 1);
  localparam int unsigned IdxW      = $clog2(K);
  localparam int unsigned WinW      = Taps * DATA_SIZE;
  localparam int unsigned AddrFullW = ADDR_SIZE + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StEmit, StDone} state_e;

  state_e                 state_q, state_d;
  logic [5:0]             n_q, n_d;
  logic [5:0]             last_q, last_d;     // outDim - 1
  logic [5:0]             r_q, r_d;
  logic [5:0]             c_q, c_d;
  logic [CntW-1:0]        cnt_q, cnt_d;       // edges spent in the current fetch
  logic [IdxW-1:0]        ti_q, ti_d;         // row/col of the tap currently on bufAddr
  logic [IdxW-1:0]        tj_q, tj_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [WinW-1:0]        win_q, win_d;
  logic [5:0]             n_clamp;
  logic                   launch;

  // Full address formed one bit wider than the buffer, then truncated.
  function automatic logic [ADDR_SIZE-1:0] tap_addr(input logic [5:0]      r,
                                                    input logic [5:0]      c,
                                                    input logic [IdxW-1:0] i,
                                                    input logic [IdxW-1:0] j,
                                                    input logic [5:0]      n);
    logic [AddrFullW-1:0] a;
    a = (AddrFullW'(r) + AddrFullW'(i)) * AddrFullW'(n) + AddrFullW'(c) + AddrFullW'(j);
    return a[ADDR_SIZE-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    last_d  = last_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ti_d    = ti_q;
    tj_d    = tj_q;
    addr_d  = addr_q;
    win_d   = win_q;
    launch  = 1'b0;
    n_clamp = (imgSize > 6'(MAX_IMG)) ? 6'(MAX_IMG) : imgSize;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d = n_clamp;
          if (n_clamp < 6'(K)) begin
            state_d = StDone;
          end else begin
            last_d = n_clamp - 6'(K);
            r_d    = '0;
            c_d    = '0;
            launch = 1'b1;
          end
        end
      end

      StFetch: begin
        // Data for the tap issued two edges ago lands in slot cnt_q - 1.
        for (int t = 0; t < int'(Taps); t++) begin
          if (cnt_q == CntW'(t + 1)) begin
            win_d[t*DATA_SIZE +: DATA_SIZE] = bus.bufData;
          end
        end
        if (cnt_q == CntW'(Taps)) begin
          state_d = StEmit;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q < CntW'(Taps - 1)) begin
            if (tj_q == IdxW'(K - 1)) begin
              tj_d = '0;
              ti_d = ti_q + IdxW'(1);
            end else begin
              tj_d = tj_q + IdxW'(1);
            end
            addr_d = tap_addr(r_q, c_q, ti_d, tj_d, n_q);
          end
        end
      end

      StEmit: begin
        if (bus.windowReady) begin
          if (c_q < last_q) begin
            c_d    = c_q + 6'(1);
            launch = 1'b1;
          end else if (r_q < last_q) begin
            c_d    = '0;
            r_d    = r_q + 6'(1);
            launch = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    // A new position puts its tap 0 on the bus at the same edge that selects it.
    if (launch) begin
      state_d = StFetch;
      cnt_d   = '0;
      ti_d    = '0;
      tj_d    = '0;
      addr_d  = tap_addr(r_d, c_d, '0, '0, n_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      last_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      ti_q    <= '0;
      tj_q    <= '0;
      addr_q  <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      last_q  <= last_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ti_q    <= ti_d;
      tj_q    <= tj_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
    end
  end

  assign bus.bufAddr     = addr_q;
  assign bus.window      = win_q;
  assign bus.windowValid = (state_q == StEmit);
  assign bus.outRow      = r_q;
  assign bus.outCol      = c_q;
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: synchronous-read buffer model, table-driven passes,
// backpressure/reset sequences and randomized passes checked against an array model.
module tb_conv_window_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] img_size;
  logic       busy;
  logic       done;

  logic [15:0] mem [1024];

  int total  = 0;
  int passed = 0;

  conv_window_feeder_if #(.DATA_SIZE(16), .ADDR_SIZE(10), .K(5)) bus ();

  conv_window_feeder #(
    .DATA_SIZE(16),
    .ADDR_SIZE(10),
    .MAX_IMG  (32),
    .K        (5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .imgSize(img_size),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Buffer returns the word one cycle after the address is presented.
  always @(posedge clk) bus.bufData <= mem[bus.bufAddr];

  typedef struct {
    int size;
    int wins;
    int lrow;
    int lcol;
    int ltap;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_w(input string name, input logic [399:0] act, input logic [399:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [399:0] exp_window(input int r, input int c, input int n);
    logic [399:0] w;
    for (int t = 0; t < 25; t++) w[t*16 +: 16] = mem[((r + t / 5) * n + c + t % 5) % 1024];
    return w;
  endfunction

  task automatic fill_identity();
    for (int a = 0; a < 1024; a++) mem[a] = 16'(a);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, 64'(bus.bufAddr), 0);
    chk_w({tag, "_window"}, bus.window, '0);
    chk({tag, "_valid"}, 64'(bus.windowValid), 0);
    chk({tag, "_row"}, 64'(bus.outRow), 0);
    chk({tag, "_col"}, 64'(bus.outCol), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
  endtask

  // mode 0: ready high; 1: random ready plus stray start pulses; 2: ready low 10 cycles.
  task automatic run_pass(input int n_req, input int mode,
                          output int nwin, output int lr, output int lc, output int ltap);
    int n, od, since, k, hold;
    bit prev_v, fin, stable;
    logic [399:0] snap_w;
    logic [9:0]   snap_a;
    logic [5:0]   snap_r, snap_c;
    n = (n_req > 32) ? 32 : n_req;
    od = n - 4;
    lr = 0; lc = 0; ltap = 0; k = 0; hold = 0; stable = 1'b1;
    snap_w = '0; snap_a = '0; snap_r = '0; snap_c = '0;
    bus.windowReady = (mode == 0);
    img_size = 6'(n_req);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    since = 0; prev_v = 1'b0; fin = 1'b0;
    for (int cyc = 0; cyc < 30000 && !fin; cyc++) begin
      if (bus.windowValid && !prev_v) begin
        if (od <= 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          chk("valid_latency", since, 26);
          chk("out_row", 64'(bus.outRow), k / od);
          chk("out_col", 64'(bus.outCol), k % od);
          chk_w("window", bus.window, exp_window(k / od, k % od, n));
        end
        snap_w = bus.window; snap_a = bus.bufAddr; snap_r = bus.outRow; snap_c = bus.outCol;
        stable = 1'b1; hold = 0;
        lr = int'(bus.outRow); lc = int'(bus.outCol); ltap = int'(bus.window[399:384]);
        k++;
      end else if (bus.windowValid) begin
        if (bus.window !== snap_w || bus.bufAddr !== snap_a ||
            bus.outRow !== snap_r || bus.outCol !== snap_c) stable = 1'b0;
      end
      if (prev_v && !bus.windowValid) begin
        since = 0;
        if (mode != 0) chk("hold_stable", 64'(stable), 1);
      end
      if (done) begin
        chk("done_latency", since, 0);
        chk("window_count", k, (od > 0) ? od * od : 0);
        start = 1'b0;
        fin = 1'b1;
      end else begin
        prev_v = bus.windowValid;
        if (mode == 1) begin
          bus.windowReady = ($urandom_range(0, 2) == 0);
          start = ($urandom_range(0, 7) == 0);
        end else if (mode == 2) begin
          bus.windowReady = bus.windowValid && (hold >= 10);
          if (bus.windowValid) hold++;
        end
        @(posedge clk); #1;
        since++;
      end
    end
    start = 1'b0;
    if (!fin) begin
      chk("pass_timeout", 0, 1);
    end else begin
      @(posedge clk); #1;
      chk("done_pulse_end", 64'(done), 0);
      chk("busy_end", 64'(busy), 0);
    end
    nwin = k;
  endtask

  initial begin
    vec_t vecs[8];
    int nwin, lr, lc, ltap;
    bit seen;

    vecs[0] = '{size: 5,  wins: 1,   lrow: 0,  lcol: 0,  ltap: 24};
    vecs[1] = '{size: 6,  wins: 4,   lrow: 1,  lcol: 1,  ltap: 35};
    vecs[2] = '{size: 3,  wins: 0,   lrow: 0,  lcol: 0,  ltap: 0};
    vecs[3] = '{size: 0,  wins: 0,   lrow: 0,  lcol: 0,  ltap: 0};
    vecs[4] = '{size: 4,  wins: 0,   lrow: 0,  lcol: 0,  ltap: 0};
    vecs[5] = '{size: 7,  wins: 9,   lrow: 2,  lcol: 2,  ltap: 48};
    vecs[6] = '{size: 9,  wins: 25,  lrow: 4,  lcol: 4,  ltap: 80};
    vecs[7] = '{size: 40, wins: 784, lrow: 27, lcol: 27, ltap: 1023};

    rst = 1'b1; start = 1'b0; img_size = '0; bus.windowReady = 1'b0;
    fill_identity();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    foreach (vecs[v]) begin
      run_pass(vecs[v].size, 0, nwin, lr, lc, ltap);
      chk("tbl_wins", nwin, vecs[v].wins);
      if (vecs[v].wins > 0) begin
        chk("tbl_last_row", lr, vecs[v].lrow);
        chk("tbl_last_col", lc, vecs[v].lcol);
        chk("tbl_last_tap", ltap, vecs[v].ltap);
      end
    end

    // Backpressure, then stray start pulses while busy.
    run_pass(6, 2, nwin, lr, lc, ltap);
    chk("bp_wins", nwin, 4);
    run_pass(6, 1, nwin, lr, lc, ltap);
    chk("start_busy_wins", nwin, 4);

    // Reset in the middle of a fetch.
    bus.windowReady = 1'b0;
    img_size = 6'd6;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset("rst_fetch");

    // Reset coinciding with a handshake: no advance.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.windowValid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("emit_reached", 64'(seen), 1);
    bus.windowReady = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.windowReady = 1'b0;
    chk_reset("rst_emit");

    run_pass(6, 0, nwin, lr, lc, ltap);
    chk("post_rst_wins", nwin, 4);

    for (int it = 0; it < 6; it++) begin
      fill_random();
      run_pass($urandom_range(3, 11), 1, nwin, lr, lc, ltap);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
